// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS main controller (Moore FSM) with retired-instruction counter
module mc_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [1:0]       ExtOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [1:0]       PCSrc,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_EXEC_I  = 4'd4,
        S_MEMADDR = 4'd5,
        S_MEMRD   = 4'd6,
        S_MEMWB   = 4'd7,
        S_MEMWR   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ALUWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            instr_cnt <= '0;
        end else begin
            state_q <= state_d;
            // leaving reset does not retire anything
            if (state_d == S_FETCH && state_q != S_IDLE)
                instr_cnt <= instr_cnt + 1'b1;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d  = state_q;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        ExtOp    = 2'b00;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        PCSrc    = 2'b00;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                PCWrite = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                // branch target computed speculatively into ALUOut
                ALUSrcB = 2'b11;
                ExtOp   = 2'b01;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_ADDU || funct == FN_SUBU) state_d = S_EXEC_R;
                        else if (funct == FN_JR)                  state_d = S_JUMP;
                        else                                      state_d = S_FETCH;
                    end
                    OP_ORI, OP_LUI: state_d = S_EXEC_I;
                    OP_LW, OP_SW:   state_d = S_MEMADDR;
                    OP_BEQ:         state_d = S_BRANCH;
                    OP_J, OP_JAL:   state_d = S_JUMP;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = (funct == FN_SUBU) ? 2'b01 : 2'b00;
                state_d = S_ALUWB;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_LUI) begin
                    ExtOp = 2'b10;
                    ALUOp = 2'b00;
                end else begin
                    ExtOp = 2'b00;
                    ALUOp = 2'b10;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = (opcode == OP_RTYPE) ? 2'b01 : 2'b00;
                state_d  = S_FETCH;
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ExtOp   = 2'b01;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                PCWrite = zero;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                PCWrite = 1'b1;
                if (opcode == OP_RTYPE) begin
                    PCSrc = 2'b11;
                end else begin
                    PCSrc = 2'b10;
                    if (opcode == OP_JAL) begin
                        RegWrite = 1'b1;
                        RegDst   = 2'b10;
                        MemtoReg = 2'b10;
                    end
                end
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl
module tb_mc_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             PCWrite, IRWrite, RegWrite, MemWrite, ALUSrcA;
    logic [1:0]       ExtOp, ALUSrcB, ALUOp, RegDst, MemtoReg, PCSrc;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_cnt;

    int checks = 0;
    int errors = 0;

    mc_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .ExtOp(ExtOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSrc(PCSrc),
        .state(state), .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [16:0] mk(input logic pcw, input logic irw, input logic rw,
                                       input logic mw, input logic [1:0] ext, input logic asa,
                                       input logic [1:0] asb, input logic [1:0] aop,
                                       input logic [1:0] rd, input logic [1:0] mtr,
                                       input logic [1:0] pcs);
        return {pcw, irw, rw, mw, ext, asa, asb, aop, rd, mtr, pcs};
    endfunction

    function automatic logic [16:0] ctl();
        return {PCWrite, IRWrite, RegWrite, MemWrite, ExtOp, ALUSrcA, ALUSrcB, ALUOp,
                RegDst, MemtoReg, PCSrc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_st(input string tag, input logic [3:0] exp_state);
        step();
        chk(tag, {28'd0, state}, {28'd0, exp_state});
    endtask

    logic [16:0] decode_ctl;

    initial begin
        decode_ctl = mk(0,0,0,0,2'b01,0,2'b11,2'b00,2'b00,2'b00,2'b00);
        reset  = 1'b1;
        opcode = 6'b000000;
        funct  = 6'b100001;
        zero   = 1'b0;
        #12;
        chk("reset_state", {28'd0, state}, 32'd0);
        chk("reset_ctl", {15'd0, ctl()}, 32'd0);
        chk("reset_cnt", {28'd0, instr_cnt}, 32'd0);

        @(negedge clk);
        reset = 1'b0;
        step_st("idle_to_fetch", 4'd1);
        chk("fetch_ctl", {15'd0, ctl()}, {15'd0, mk(1,1,0,0,2'b00,0,2'b01,2'b00,2'b00,2'b00,2'b00)});
        chk("fetch_cnt", {28'd0, instr_cnt}, 32'd0);

        // addu
        step_st("addu_decode", 4'd2);
        chk("decode_ctl", {15'd0, ctl()}, {15'd0, decode_ctl});
        step_st("addu_exec", 4'd3);
        chk("addu_exec_ctl", {15'd0, ctl()}, {15'd0, mk(0,0,0,0,2'b00,1,2'b00,2'b00,2'b00,2'b00,2'b00)});
        step_st("addu_wb", 4'd10);
        chk("addu_wb_ctl", {15'd0, ctl()}, {15'd0, mk(0,0,1,0,2'b00,0,2'b00,2'b00,2'b01,2'b00,2'b00)});
        step_st("addu_done", 4'd1);
        chk("addu_cnt", {28'd0, instr_cnt}, 32'd1);

        // subu
        funct = 6'b100011;
        step_st("subu_decode", 4'd2);
        step_st("subu_exec", 4'd3);
        chk("subu_exec_ctl", {15'd0, ctl()}, {15'd0, mk(0,0,0,0,2'b00,1,2'b00,2'b01,2'b00,2'b00,2'b00)});
        step_st("subu_wb", 4'd10);
        step_st("subu_done", 4'd1);
        chk("subu_cnt", {28'd0, instr_cnt}, 32'd2);

        // lui
        opcode = 6'b001111;
        step_st("lui_decode", 4'd2);
        step_st("lui_exec", 4'd4);
        chk("lui_exec_ctl", {15'd0, ctl()}, {15'd0, mk(0,0,0,0,2'b10,1,2'b10,2'b00,2'b00,2'b00,2'b00)});
        step_st("lui_wb", 4'd10);
        chk("lui_wb_ctl", {15'd0, ctl()}, {15'd0, mk(0,0,1,0,2'b00,0,2'b00,2'b00,2'b00,2'b00,2'b00)});
        step_st("lui_done", 4'd1);

        // ori
        opcode = 6'b001101;
        step_st("ori_decode", 4'd2);
        step_st("ori_exec", 4'd4);
        chk("ori_exec_ctl", {15'd0, ctl()}, {15'd0, mk(0,0,0,0,2'b00,1,2'b10,2'b10,2'b00,2'b00,2'b00)});
        step_st("ori_wb", 4'd10);
        step_st("ori_done", 4'd1);
        chk("ori_cnt", {28'd0, instr_cnt}, 32'd4);

        // lw
        opcode = 6'b100011;
        step_st("lw_decode", 4'd2);
        step_st("lw_addr", 4'd5);
        chk("lw_addr_ctl", {15'd0, ctl()}, {15'd0, mk(0,0,0,0,2'b01,1,2'b10,2'b00,2'b00,2'b00,2'b00)});
        step_st("lw_rd", 4'd6);
        chk("lw_rd_ctl", {15'd0, ctl()}, 32'd0);
        step_st("lw_wb", 4'd7);
        chk("lw_wb_ctl", {15'd0, ctl()}, {15'd0, mk(0,0,1,0,2'b00,0,2'b00,2'b00,2'b00,2'b01,2'b00)});
        step_st("lw_done", 4'd1);

        // sw
        opcode = 6'b101011;
        step_st("sw_decode", 4'd2);
        step_st("sw_addr", 4'd5);
        step_st("sw_wr", 4'd8);
        chk("sw_wr_ctl", {15'd0, ctl()}, {15'd0, mk(0,0,0,1,2'b00,0,2'b00,2'b00,2'b00,2'b00,2'b00)});
        step_st("sw_done", 4'd1);
        chk("sw_cnt", {28'd0, instr_cnt}, 32'd6);

        // beq taken, then zero dropped combinationally
        opcode = 6'b000100;
        zero   = 1'b1;
        step_st("beq1_decode", 4'd2);
        step_st("beq1_branch", 4'd9);
        chk("beq_taken_ctl", {15'd0, ctl()}, {15'd0, mk(1,0,0,0,2'b00,1,2'b00,2'b01,2'b00,2'b00,2'b01)});
        zero = 1'b0;
        #1;
        chk("beq_comb_pcwrite", {31'd0, PCWrite}, 32'd0);
        step_st("beq1_done", 4'd1);

        // beq not taken
        step_st("beq2_decode", 4'd2);
        step_st("beq2_branch", 4'd9);
        chk("beq_nt_ctl", {15'd0, ctl()}, {15'd0, mk(0,0,0,0,2'b00,1,2'b00,2'b01,2'b00,2'b00,2'b01)});
        step_st("beq2_done", 4'd1);
        chk("beq_cnt", {28'd0, instr_cnt}, 32'd8);

        // j
        opcode = 6'b000010;
        step_st("j_decode", 4'd2);
        step_st("j_jump", 4'd11);
        chk("j_ctl", {15'd0, ctl()}, {15'd0, mk(1,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00,2'b10)});
        step_st("j_done", 4'd1);

        // jal
        opcode = 6'b000011;
        step_st("jal_decode", 4'd2);
        step_st("jal_jump", 4'd11);
        chk("jal_ctl", {15'd0, ctl()}, {15'd0, mk(1,0,1,0,2'b00,0,2'b00,2'b00,2'b10,2'b10,2'b10)});
        step_st("jal_done", 4'd1);

        // jr
        opcode = 6'b000000;
        funct  = 6'b001000;
        step_st("jr_decode", 4'd2);
        step_st("jr_jump", 4'd11);
        chk("jr_ctl", {15'd0, ctl()}, {15'd0, mk(1,0,0,0,2'b00,0,2'b00,2'b00,2'b00,2'b00,2'b11)});
        step_st("jr_done", 4'd1);
        chk("jr_cnt", {28'd0, instr_cnt}, 32'd11);

        // unsupported opcode retires as nop
        opcode = 6'b111111;
        step_st("nop_decode", 4'd2);
        chk("nop_decode_ctl", {15'd0, ctl()}, {15'd0, decode_ctl});
        step_st("nop_done", 4'd1);
        chk("nop_cnt", {28'd0, instr_cnt}, 32'd12);

        // unsupported R-type funct
        opcode = 6'b000000;
        funct  = 6'b000000;
        step_st("rnop_decode", 4'd2);
        step_st("rnop_done", 4'd1);
        chk("rnop_cnt", {28'd0, instr_cnt}, 32'd13);

        // counter wrap at 2^CNT_W
        opcode = 6'b111111;
        step(); step();
        step(); step();
        chk("cnt_max", {28'd0, instr_cnt}, 32'd15);
        step();
        step_st("wrap_fetch", 4'd1);
        chk("cnt_wrap", {28'd0, instr_cnt}, 32'd0);

        // asynchronous reset in the middle of lw
        opcode = 6'b100011;
        step_st("rst_lw_decode", 4'd2);
        step_st("rst_lw_addr", 4'd5);
        step_st("rst_lw_rd", 4'd6);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_state", {28'd0, state}, 32'd0);
        chk("async_rst_ctl", {15'd0, ctl()}, 32'd0);
        chk("async_rst_cnt", {28'd0, instr_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step_st("rst_release_fetch", 4'd1);
        chk("rst_release_ctl", {15'd0, ctl()}, {15'd0, mk(1,1,0,0,2'b00,0,2'b01,2'b00,2'b00,2'b00,2'b00)});
        chk("rst_release_cnt", {28'd0, instr_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
